uart_tx_fifo: RTL

//  Memory-mapped UART transmitter for the RISC-V SoC, the device-to-host path.
//  The CPU IO write path pushes bytes into a small FIFO. A serialiser shifts them
//  out 8N1, LSB first, on the tx pin to the Tang Nano 9K USB-UART bridge.
//  It gives firmware a character output channel alongside the LEDs.

---
 rtl/uart_tx_fifo_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/uart_tx_fifo.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: serialiser state encodings and baud-divisor derivation.
// Kept separate so a future uart_rx can reuse the same encodings and divisor math.
package uart_tx_fifo_pkg;

    // Serialiser states; encodings are fixed so other UART blocks can share them.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } uart_state_e;

    localparam int unsigned DataBits = 8;

    // Clock cycles per serial bit, rounded down; callers must ensure the result is >= 2.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count; a push into a full FIFO is dropped
// even when a pop happens on the same edge, and a pop from an empty FIFO is ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [LvlW-1:0]  level_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == LvlW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage array: written only on an accepted push, no reset needed for data.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; level tracks the count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + 1'b1;
            end else if (do_pop && !do_push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmitter: CPU writes land in a small FIFO and an 8N1,
// LSB-first serialiser drains it onto a registered, idle-high tx line.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 27_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            wr_valid,
    input  logic [7:0]                      wr_data,
    output logic                            wr_ready,
    output logic                            tx,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level
);

    localparam int unsigned ClksPerBit = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned CntW       = $clog2(ClksPerBit);
    localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);

    uart_state_e          state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DataBits-1:0]  shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DataBits-1:0]  fifo_dout;

    assign wr_ready = ~fifo_full;
    assign tx       = tx_q;
    assign busy     = (state_q != StIdle) | (level != '0);

    sync_fifo #(
        .WIDTH (DataBits),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (wr_valid & wr_ready),
        .pop    (pop),
        .din    (wr_data),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (level)
    );

    // Serialiser registers; reset drops any in-flight frame and forces the line idle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic; tx is computed here so it changes on the same edge as the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    bit_d   = '0;
                    cnt_d   = '0;
                    tx_d    = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == CntMax) begin
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = StData;
                end
            end
            StData: begin
                if (cnt_q == CntMax) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        shift_d = {1'b0, shift_q[DataBits-1:1]};
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (cnt_q == CntMax) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit so frames stay contiguous.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        bit_d   = '0;
                        tx_d    = 1'b0;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule
